// File: rtl/adder_rr_scheduler_if.sv
// Operand/result bus between the per-lane producers, the shared adder
// scheduler and the downstream accumulation stage.
interface adder_rr_scheduler_if #(
    parameter int A       = 8,
    parameter int B       = 8,
    parameter int ADDER_O = A + 1,
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ)
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*A-1:0] req_a;
    logic [N_REQ*B-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic               res_valid;
    logic               res_ready;
    logic [ADDER_O-1:0] res_data;
    logic [ID_W-1:0]    res_id;
    logic [15:0]        op_count;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id, op_count
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id, op_count
    );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one signed adder among N_REQ requesters.
// One registered result slot; a consume and a new grant may happen on the
// same edge so a continuously ready sink sees one result per cycle.
// B must not exceed A.
//
// state  | meaning
// S_IDLE | result register empty
// S_FULL | result register holds a valid sum (res_valid=1)
module adder_rr_scheduler #(
    parameter int A       = 8,
    parameter int B       = 8,
    parameter int ADDER_O = A + 1,
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    adder_rr_scheduler_if.slave  bus
);

    typedef enum logic {S_IDLE = 1'b0, S_FULL = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_res_id;
    logic [ADDER_O-1:0] r_res_data;
    logic [15:0]        r_op_count;

    logic               w_can_accept;
    logic               w_res_xfer;
    logic               w_found;
    logic               w_grant;
    logic [ID_W-1:0]    w_scan_idx;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [N_REQ-1:0]   w_req_ready;
    logic [A-1:0]       w_a;
    logic [B-1:0]       w_b;
    logic [ADDER_O-1:0] w_sum;
    logic [A-1:0]       w_lane_a [N_REQ];
    logic [B-1:0]       w_lane_b [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign w_lane_a[gi] = bus.req_a[gi*A +: A];
        assign w_lane_b[gi] = bus.req_b[gi*B +: B];
    end

    assign w_res_xfer   = (r_state == S_FULL) & bus.res_ready;
    assign w_can_accept = (r_state == S_IDLE) | w_res_xfer;

    // Round-robin search from rr_ptr; grant is masked during reset and
    // never looks at operand data.
    always_comb begin
        w_found     = 1'b0;
        w_scan_idx  = '0;
        w_gnt_idx   = '0;
        w_req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan_idx = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && bus.req_valid[w_scan_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
        w_grant = w_found & w_can_accept & i_resetn;
        if (w_grant) begin
            w_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Full-precision add: both operands sign-extended to the result width
    assign w_a   = w_lane_a[w_gnt_idx];
    assign w_b   = w_lane_b[w_gnt_idx];
    assign w_sum = {{(ADDER_O-A){w_a[A-1]}}, w_a} + {{(ADDER_O-B){w_b[B-1]}}, w_b};

    // Next-state: a grant always fills the slot; a consume without grant empties it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_FULL;
            S_FULL: begin
                if (w_grant)            w_state_nxt = S_FULL;
                else if (bus.res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Result slot captures the sum and lane ID on every grant, holds otherwise
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_res_data <= '0;
            r_res_id   <= '0;
        end else if (w_grant) begin
            r_res_data <= w_sum;
            r_res_id   <= w_gnt_idx;
        end
    end

    // Round-robin pointer advances past the granted lane
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)    r_rr_ptr <= '0;
        else if (w_grant) r_rr_ptr <= w_ptr_nxt;
    end

    // Completed-result counter, free-running wrap at 16 bits
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)       r_op_count <= '0;
        else if (w_res_xfer) r_op_count <= r_op_count + 16'd1;
    end

    assign bus.req_ready = w_req_ready;
    assign bus.res_valid = (r_state == S_FULL);
    assign bus.res_data  = r_res_data;
    assign bus.res_id    = r_res_id;
    assign bus.op_count  = r_op_count;

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one signed adder datapath among N_REQ requesters using valid/ready handshakes and round-robin arbitration.
- Each accepted operand pair produces a registered, full-precision signed sum tagged with the requester ID.
- Sits between the per-lane operand producers and the downstream accumulation stage of the compute array.

Parameters:
- A, 8, width of operand a (two's complement).
- B, 8, width of operand b (two's complement); B <= A is required.
- ADDER_O, A+1, result width; sum of sign-extended operands.
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the requester ID.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_resetn  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester operand valid.
- req_a  input  N_REQ*A  packed operand a; lane i is bits [i*A +: A].
- req_b  input  N_REQ*B  packed operand b; lane i is bits [i*B +: B].
- req_ready  output  N_REQ  one-hot grant; a lane's transfer occurs when its req_valid and req_ready are both 1.
- res_valid  output  1  result register holds a valid sum.
- res_ready  input  1  downstream accepts the result.
- res_data  output  ADDER_O  signed sum.
- res_id  output  ID_W  index of the requester that produced res_data.
- op_count  output  16  number of completed result transfers; wraps at 65535 -> 0.

Behaviour:
- Reset (async assert, sync release): res_valid=0, res_data=0, res_id=0, op_count=0, rr_ptr=0, state=IDLE. Any in-flight result is discarded.
- req_ready is 0 while i_resetn is low.
- FSM has two states:
  - IDLE: result register empty.
  - FULL: res_valid=1, result held.
- can_accept = (state==IDLE) | (state==FULL & res_ready).
- Arbitration:
  - When can_accept=1, req_ready is combinationally one-hot on the first lane with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - When can_accept=0 or no lane is valid, req_ready is all zeros.
  - req_ready must not depend on req_a or req_b.
- On a grant to lane g:
  - Next edge: res_data <= sext(req_a[g]) + sext(req_b[g]), res_id <= g, res_valid <= 1, state <= FULL.
  - rr_ptr <= (g+1) mod N_REQ.
- rr_ptr is unchanged on cycles with no grant.
- Latency: 1 cycle from transfer to res_valid.
- Throughput: 1 operation per cycle when res_ready is held at 1.
- Result transfer (res_valid & res_ready):
  - op_count increments by 1.
  - If no new grant occurs in the same cycle: res_valid <= 0, state <= IDLE, and res_data/res_id hold their last value.
- Simultaneous consume and grant in FULL: the new result replaces the old one on the same edge and res_valid stays 1 (no bubble).
- Backpressure: while FULL and res_ready=0, res_data, res_id and res_valid stay stable and req_ready=0.
- Arithmetic: both operands are sign-extended to ADDER_O bits before the add, so no overflow is possible; b is extended from B bits.
- Requesters may drop req_valid without a grant; the scheduler does not latch un-granted requests.

Test Plan:
- Single request, lane 0, a=48, b=20, res_ready=1 -> req_ready=4'b0001 in the same cycle; next cycle res_valid=1, res_data=68 (9'h044), res_id=0.
- Lane 2, a=-4 (8'hFC), b=2 -> res_data=-2 (9'h1FE), res_id=2. Then a=127, b=127 -> 254 (9'h0FE). Then a=-128, b=-128 -> -256 (9'h100).
- All four lanes valid continuously, res_ready=1, rr_ptr=0 -> grants 0,1,2,3,0,1 on consecutive cycles; res_id follows one cycle later; op_count=6 after 6 results.
- Backpressure: result pending, res_ready=0 for 3 cycles with lanes 1 and 3 valid -> req_ready=0 and res_data stable. Raise res_ready -> same-cycle grant to lane 1 (rr_ptr=1), next result has res_id=1 with no bubble.
- Assert i_resetn low mid-stream with res_valid=1 -> res_valid, op_count and rr_ptr immediately 0. After release, lane 3 alone valid -> granted on the first cycle.
- op_count preloaded by running 65535 transfers -> the next transfer wraps op_count to 0.
